// File: rtl/fact_pkg.sv
// Shared definitions for the factorial job scheduler: default sizes,
// FSM state encodings and a small index-width helper.
package fact_pkg;

  localparam int NREQ_D = 4;
  localparam int NW_D   = 4;
  localparam int RW_D   = 32;
  localparam int TMO_D  = 1023;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLR   = 3'd1;
  localparam state_t S_GO    = 3'd2;
  localparam state_t S_BUSY  = 3'd3;
  localparam state_t S_RESP  = 3'd4;
  localparam state_t S_ABORT = 3'd5;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fact_sched_rr_pick.sv
// Round-robin picker: scans requesters starting at ptr and wrapping,
// returning a one-hot grant for the first active one (zero if none).
module rr_pick
  import fact_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int IW   = idx_w(NREQ_D)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;
  logic          found;

  // Rotated priority scan; the first requester at or after ptr wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fact_sched.sv
// Factorial job scheduler: arbitrates NREQ requesters onto one shared
// factorial unit, sequences clear/go, watches for a hung unit and returns
// a one-cycle done pulse with the result (or an abort) to the owner.
module fact_sched
  import fact_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int NW   = NW_D,
  parameter int RW   = RW_D,
  parameter int TMO  = TMO_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic [RW-1:0]    result,
  output logic             fact_clr,
  output logic             fact_go,
  output logic [NW-1:0]    fact_n,
  input  logic             fact_fine,
  input  logic [RW-1:0]    fact_result
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(TMO + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic [NW-1:0]   op;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   res_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick)
  );

  // Encode the one-hot pick into an index for operand selection and ptr update.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) pick_idx = IW'(k);
    end
  end

  assign nxt_ptr = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

  // Control FSM, watchdog counter, round-robin pointer and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        S_IDLE:  if (|req) state <= S_CLR;
        S_CLR:   state <= S_GO;
        S_GO: begin
          state <= S_BUSY;
          cnt   <= '0;
        end
        S_BUSY: begin
          cnt <= cnt + CW'(1);
          // A finished unit wins over a watchdog expiry in the same cycle.
          if (fact_fine) begin
            state <= S_RESP;
            res_q <= fact_result;
          end else if (cnt == CW'(TMO)) begin
            state <= S_ABORT;
            res_q <= '0;
          end
        end
        S_RESP, S_ABORT: begin
          state <= S_IDLE;
          ptr   <= nxt_ptr;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch the winner and its operand when a job is accepted; later req_n changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && |req) begin
      win_oh  <= pick;
      win_idx <= pick_idx;
      op      <= req_n[pick_idx*NW +: NW];
    end
  end

  assign gnt      = (state != S_IDLE) ? win_oh : '0;
  assign done     = (state == S_RESP || state == S_ABORT) ? win_oh : '0;
  assign err      = (state == S_ABORT);
  assign result   = res_q;
  assign fact_clr = rst | (state == S_CLR);
  assign fact_go  = (state == S_GO);
  assign fact_n   = op;

endmodule

// File: tb/tb_fact_sched.sv
// Scenario bench for fact_sched with a behavioural factorial unit stub and
// an expected-result queue filled as jobs are requested.
module tb_fact_sched;

  localparam int NREQ = 4;
  localparam int NW   = 4;
  localparam int RW   = 32;
  localparam int TMO  = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [15:0]     req_n;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic            err;
  logic [31:0]     result;
  logic            fact_clr;
  logic            fact_go;
  logic [3:0]      fact_n;
  logic            fact_fine = 1'b0;
  logic [31:0]     fact_result = '0;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   lat = 2;
  int   w   = 0;
  logic run = 1'b0;
  int   clr_cnt = 0;
  int   go_cnt  = 0;
  int   done_evt = 0;

  always #5 clk = ~clk;

  fact_sched #(
    .NREQ (NREQ),
    .NW   (NW),
    .RW   (RW),
    .TMO  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_n       (req_n),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .result      (result),
    .fact_clr    (fact_clr),
    .fact_go     (fact_go),
    .fact_n      (fact_n),
    .fact_fine   (fact_fine),
    .fact_result (fact_result)
  );

  function automatic logic [31:0] fact_f(input logic [3:0] n);
    logic [31:0] a;
    a = 32'd1;
    for (int i = 2; i <= int'(n); i++) a = a * 32'(i);
    return a;
  endfunction

  // Factorial unit stub: raises fact_fine 'lat' cycles into BUSY and holds it.
  always @(posedge clk) begin
    if (fact_clr) begin
      run <= 1'b0; fact_fine <= 1'b0; w <= 0;
    end else if (fact_go) begin
      run <= 1'b1; fact_fine <= 1'b0; w <= 0;
    end else if (run && !fact_fine) begin
      w <= w + 1;
      if (w + 1 == lat) begin
        fact_fine   <= 1'b1;
        fact_result <= fact_f(fact_n);
      end
    end
  end

  // Pulse and event counters observed by the scenarios.
  always @(posedge clk) begin
    if (fact_clr === 1'b1) clr_cnt <= clr_cnt + 1;
    if (fact_go === 1'b1)  go_cnt  <= go_cnt + 1;
    if (done !== 4'b0)     done_evt <= done_evt + 1;
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; req = '0; req_n = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_done(input int limit, output bit got, output int cycles);
    got = 1'b0; cycles = 0;
    while (!got && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done !== 4'b0) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; req_n = 16'h1111;
    repeat (2) @(negedge clk);
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    total++; if (fact_go !== 1'b0) begin bad++; $display("FAIL reset_go: got %b want 0", fact_go); end
    total++; if (fact_clr !== 1'b1) begin bad++; $display("FAIL reset_clr: got %b want 1", fact_clr); end
    rst = 1'b0; req = '0;
    @(negedge clk);
    total++; if (fact_clr !== 1'b0) begin bad++; $display("FAIL reset_clr_release: got %b want 0", fact_clr); end
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_idle_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_single;
    exp_t ex; bit got; int cyc; int c0; int g0;
    do_reset;
    c0 = clr_cnt; g0 = go_cnt;
    lat = 4; req_n = 16'h0005; req = 4'b0001;
    exp_q.push_back('{idx: 0, res: 32'd120, er: 1'b0});
    @(negedge clk);
    total++; if ({gnt, fact_clr, fact_go} !== {4'b0001, 1'b1, 1'b0}) begin bad++; $display("FAIL single_clr_cycle: got gnt=%b clr=%b go=%b want 0001 1 0", gnt, fact_clr, fact_go); end
    @(negedge clk);
    total++; if ({gnt, fact_clr, fact_go} !== {4'b0001, 1'b0, 1'b1}) begin bad++; $display("FAIL single_go_cycle: got gnt=%b clr=%b go=%b want 0001 0 1", gnt, fact_clr, fact_go); end
    @(negedge clk);
    total++; if ({gnt, fact_clr, fact_go, fact_n} !== {4'b0001, 1'b0, 1'b0, 4'd5}) begin bad++; $display("FAIL single_busy: got gnt=%b clr=%b go=%b n=%0d want 0001 0 0 5", gnt, fact_clr, fact_go, fact_n); end
    wait_done(50, got, cyc);
    ex = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL single_timeout: no done within 50 cycles"); end
    else begin
      req = '0;
      if (done !== 4'(1 << ex.idx) || err !== ex.er || result !== ex.res) begin
        bad++; $display("FAIL single_done: got done=%b err=%b result=%0d want %b %b %0d", done, err, result, 4'(1 << ex.idx), ex.er, ex.res);
      end
      @(negedge clk);
      total++; if (done !== 4'b0 || gnt !== 4'b0) begin bad++; $display("FAIL single_pulse: got done=%b gnt=%b want 0000 0000", done, gnt); end
    end
    total++; if (clr_cnt - c0 != 1) begin bad++; $display("FAIL single_clr_count: got %0d want 1", clr_cnt - c0); end
    total++; if (go_cnt - g0 != 1) begin bad++; $display("FAIL single_go_count: got %0d want 1", go_cnt - g0); end
    req = '0;
  endtask

  task automatic test_all;
    exp_t ex; bit got; int cyc;
    do_reset;
    lat = 2; req_n = {4'd4, 4'd3, 4'd2, 4'd1}; req = 4'b1111;
    exp_q.push_back('{idx: 0, res: 32'd1,  er: 1'b0});
    exp_q.push_back('{idx: 1, res: 32'd2,  er: 1'b0});
    exp_q.push_back('{idx: 2, res: 32'd6,  er: 1'b0});
    exp_q.push_back('{idx: 3, res: 32'd24, er: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_done(40, got, cyc);
      ex = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL all_timeout: job %0d no done within 40 cycles", k); end
      else begin
        if (done !== 4'(1 << ex.idx) || err !== ex.er || result !== ex.res) begin
          bad++; $display("FAIL all_done: job %0d got done=%b err=%b result=%0d want %b %b %0d", k, done, err, result, 4'(1 << ex.idx), ex.er, ex.res);
        end
        req = req & ~done;
        @(negedge clk);
        total++; if (done !== 4'b0) begin bad++; $display("FAIL all_pulse: job %0d got done=%b want 0000", k, done); end
      end
    end
    req = '0;
  endtask

  task automatic test_fair;
    exp_t ex; bit got; int cyc;
    do_reset;
    lat = 2; req_n = 16'h0302; req = 4'b0101;
    exp_q.push_back('{idx: 0, res: 32'd2, er: 1'b0});
    exp_q.push_back('{idx: 2, res: 32'd6, er: 1'b0});
    exp_q.push_back('{idx: 0, res: 32'd2, er: 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_done(40, got, cyc);
      ex = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL fair_timeout: job %0d no done within 40 cycles", k); end
      else if (done !== 4'(1 << ex.idx) || result !== ex.res) begin
        bad++; $display("FAIL fair_order: job %0d got done=%b result=%0d want %b %0d", k, done, result, 4'(1 << ex.idx), ex.res);
      end
      if (done[2]) req[2] = 1'b0;
      if (k == 2) req = '0;
    end
    req = '0;
  endtask

  task automatic test_watchdog;
    exp_t ex; bit got; int cyc; int gcyc; int dcyc;
    do_reset;
    lat = 2; req_n = 16'h0053; req = 4'b0001;
    exp_q.push_back('{idx: 0, res: 32'd6, er: 1'b0});
    wait_done(40, got, cyc);
    ex = exp_q.pop_front();
    req = '0;
    total++;
    if (!got || done !== 4'(1 << ex.idx) || result !== ex.res || err !== ex.er) begin
      bad++; $display("FAIL wdog_prejob: got seen=%0d done=%b result=%0d want 1 %b %0d", got, done, result, 4'(1 << ex.idx), ex.res);
    end
    @(negedge clk);
    lat = 100000; req = 4'b0010;
    exp_q.push_back('{idx: 1, res: 32'd0, er: 1'b1});
    gcyc = -1; dcyc = -1;
    for (int n = 0; n < 200 && dcyc < 0; n++) begin
      @(negedge clk);
      if (fact_go === 1'b1 && gcyc < 0) gcyc = n;
      if (done !== 4'b0) dcyc = n;
    end
    ex = exp_q.pop_front();
    req = '0;
    total++;
    if (dcyc < 0) begin bad++; $display("FAIL wdog_timeout: no done within 200 cycles"); end
    else begin
      if (dcyc - gcyc - 1 != TMO + 1) begin bad++; $display("FAIL wdog_busy_cycles: got %0d want %0d", dcyc - gcyc - 1, TMO + 1); end
      total++; if (done !== 4'(1 << ex.idx)) begin bad++; $display("FAIL wdog_done: got %b want %b", done, 4'(1 << ex.idx)); end
      total++; if (err !== ex.er) begin bad++; $display("FAIL wdog_err: got %b want %b", err, ex.er); end
      total++; if (result !== ex.res) begin bad++; $display("FAIL wdog_result: got %0d want %0d", result, ex.res); end
    end
  endtask

  task automatic test_simul;
    exp_t ex; int gcyc; int dcyc;
    do_reset;
    lat = TMO; req_n = 16'h0004; req = 4'b0001;
    exp_q.push_back('{idx: 0, res: 32'd24, er: 1'b0});
    gcyc = -1; dcyc = -1;
    for (int n = 0; n < 200 && dcyc < 0; n++) begin
      @(negedge clk);
      if (fact_go === 1'b1 && gcyc < 0) gcyc = n;
      if (done !== 4'b0) dcyc = n;
    end
    ex = exp_q.pop_front();
    req = '0;
    total++;
    if (dcyc < 0) begin bad++; $display("FAIL simul_timeout: no done within 200 cycles"); end
    else begin
      if (err !== ex.er || result !== ex.res || done !== 4'(1 << ex.idx)) begin
        bad++; $display("FAIL simul_resp: got done=%b err=%b result=%0d want %b %b %0d", done, err, result, 4'(1 << ex.idx), ex.er, ex.res);
      end
      total++; if (dcyc - gcyc - 1 != TMO + 1) begin bad++; $display("FAIL simul_busy_cycles: got %0d want %0d", dcyc - gcyc - 1, TMO + 1); end
    end
  endtask

  task automatic test_reset_mid;
    exp_t ex; bit got; int cyc; int ev0;
    do_reset;
    lat = 2; req_n = 16'h0020; req = 4'b0010;
    exp_q.push_back('{idx: 1, res: 32'd2, er: 1'b0});
    wait_done(40, got, cyc);
    ex = exp_q.pop_front();
    req = '0;
    total++;
    if (!got || done !== 4'(1 << ex.idx) || result !== ex.res) begin
      bad++; $display("FAIL rstmid_prejob: got seen=%0d done=%b result=%0d want 1 %b %0d", got, done, result, 4'(1 << ex.idx), ex.res);
    end
    @(negedge clk);
    lat = 100000; req_n = 16'h0503; req = 4'b0100;
    repeat (4) @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rstmid_busy_gnt: got %b want 0100", gnt); end
    ev0 = done_evt;
    rst = 1'b1; req = '0;
    @(negedge clk);
    total++; if (gnt !== 4'b0 || fact_clr !== 1'b1 || done !== 4'b0) begin bad++; $display("FAIL rstmid_in_reset: got gnt=%b clr=%b done=%b want 0000 1 0000", gnt, fact_clr, done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done_evt != ev0) begin bad++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_evt - ev0); end
    lat = 3; req = 4'b0101;
    exp_q.push_back('{idx: 0, res: 32'd6, er: 1'b0});
    wait_done(40, got, cyc);
    ex = exp_q.pop_front();
    req = '0;
    total++;
    if (!got) begin bad++; $display("FAIL rstmid_timeout: no done within 40 cycles"); end
    else if (done !== 4'(1 << ex.idx) || result !== ex.res || err !== ex.er) begin
      bad++; $display("FAIL rstmid_after: got done=%b err=%b result=%0d want %b %b %0d", done, err, result, 4'(1 << ex.idx), ex.er, ex.res);
    end
  endtask

  task automatic test_job_props;
    exp_t ex; bit got; int cyc;
    logic [3:0]  nv [3];
    logic [31:0] rv [3];
    nv[0] = 4'd6;  rv[0] = 32'd720;
    nv[1] = 4'd0;  rv[1] = 32'd1;
    nv[2] = 4'd13; rv[2] = 32'd1932053504;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lat = 3; req_n = {12'h000, nv[k]}; req = 4'b0001;
      exp_q.push_back('{idx: 0, res: rv[k], er: 1'b0});
      @(negedge clk);
      req = '0; req_n = 16'hFFFF;
      repeat (2) @(negedge clk);
      total++; if (fact_n !== nv[k]) begin bad++; $display("FAIL props_operand_held: job %0d got %0d want %0d", k, fact_n, nv[k]); end
      wait_done(40, got, cyc);
      ex = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL props_timeout: job %0d no done within 40 cycles", k); end
      else if (done !== 4'(1 << ex.idx) || result !== ex.res || err !== ex.er) begin
        bad++; $display("FAIL props_done: job %0d got done=%b err=%b result=%0d want %b %b %0d", k, done, err, result, 4'(1 << ex.idx), ex.er, ex.res);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_n = '0;
    test_reset;
    test_single;
    test_all;
    test_fair;
    test_watchdog;
    test_simul;
    test_reset_mid;
    test_job_props;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
